// File: rtl/funct_generator_div.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor, radix-2 restoring on magnitudes,
// one quotient bit per clock followed by a sign-fix cycle.
module funct_generator_div #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enh,
  input  logic signed [2*DATA_WIDTH-1:0] data_i,
  input  logic signed [DATA_WIDTH-1:0]   b_i,
  output logic signed [2*DATA_WIDTH-1:0] quot_o,
  output logic signed [DATA_WIDTH-1:0]   rem_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           div_zero_o
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned DW = 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e          r_state, w_state_nxt;
  logic [DW-1:0]   r_dvd, w_dvd_nxt;   // dividend magnitude, becomes quotient magnitude
  logic [W-1:0]    r_dvs, w_dvs_nxt;
  logic [W:0]      r_prem, w_prem_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_neg_a, w_neg_a_nxt;
  logic            r_neg_b, w_neg_b_nxt;
  logic            r_dz, w_dz_nxt;
  logic [DW-1:0]   r_quot, w_quot_nxt;
  logic [W-1:0]    r_rem, w_rem_nxt;
  logic            r_done, w_done_nxt;
  logic            r_dz_out, w_dz_out_nxt;

  logic [DW-1:0]   w_abs_a;
  logic [W-1:0]    w_abs_b;
  logic [W:0]      w_shift;
  logic [W:0]      w_sub;
  logic            w_ge;

  // Unary minus wraps -2^(N-1) onto itself, which is the correct unsigned magnitude.
  assign w_abs_a = data_i[DW-1] ? $unsigned(-data_i) : $unsigned(data_i);
  assign w_abs_b = b_i[W-1] ? $unsigned(-b_i) : $unsigned(b_i);

  assign w_shift = {r_prem[W-1:0], r_dvd[DW-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift - {1'b0, r_dvs};

  always_comb begin
    w_state_nxt  = r_state;
    w_dvd_nxt    = r_dvd;
    w_dvs_nxt    = r_dvs;
    w_prem_nxt   = r_prem;
    w_cnt_nxt    = r_cnt;
    w_neg_a_nxt  = r_neg_a;
    w_neg_b_nxt  = r_neg_b;
    w_dz_nxt     = r_dz;
    w_quot_nxt   = r_quot;
    w_rem_nxt    = r_rem;
    w_done_nxt   = 1'b0;
    w_dz_out_nxt = r_dz_out;

    unique case (r_state)
      StIdle: begin
        if (enh) begin
          w_dvd_nxt   = w_abs_a;
          w_dvs_nxt   = w_abs_b;
          w_neg_a_nxt = data_i[DW-1];
          w_neg_b_nxt = b_i[W-1];
          w_dz_nxt    = (b_i == '0);
          w_prem_nxt  = '0;
          w_cnt_nxt   = CW'(DW);
          w_state_nxt = (b_i == '0) ? StFix : StCalc;
        end
      end
      StCalc: begin
        if (w_ge) begin
          w_prem_nxt = w_sub;
          w_dvd_nxt  = {r_dvd[DW-2:0], 1'b1};
        end else begin
          w_prem_nxt = w_shift;
          w_dvd_nxt  = {r_dvd[DW-2:0], 1'b0};
        end
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = StFix;
        end
      end
      StFix: begin
        if (r_dz) begin
          w_quot_nxt   = '0;
          w_rem_nxt    = '0;
          w_dz_out_nxt = 1'b1;
        end else begin
          w_quot_nxt   = (r_neg_a ^ r_neg_b) ? -r_dvd : r_dvd;
          w_rem_nxt    = r_neg_a ? -r_prem[W-1:0] : r_prem[W-1:0];
          w_dz_out_nxt = 1'b0;
        end
        w_done_nxt  = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_prem   <= '0;
      r_cnt    <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_dz     <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_done   <= 1'b0;
      r_dz_out <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dvd    <= w_dvd_nxt;
      r_dvs    <= w_dvs_nxt;
      r_prem   <= w_prem_nxt;
      r_cnt    <= w_cnt_nxt;
      r_neg_a  <= w_neg_a_nxt;
      r_neg_b  <= w_neg_b_nxt;
      r_dz     <= w_dz_nxt;
      r_quot   <= w_quot_nxt;
      r_rem    <= w_rem_nxt;
      r_done   <= w_done_nxt;
      r_dz_out <= w_dz_out_nxt;
    end
  end

  assign quot_o     = $signed(r_quot);
  assign rem_o      = $signed(r_rem);
  assign busy_o     = (r_state != StIdle);
  assign done_o     = r_done;
  assign div_zero_o = r_dz_out;

endmodule

// File: tb/tb_funct_generator_div.sv
// Bench for funct_generator_div: directed vector table, randomized ops against an arithmetic
// reference, plus busy-time interference, async reset and continuous-enh sequences.
module tb_funct_generator_div;

  localparam int unsigned W = 16;

  logic                  clk;
  logic                  rst;
  logic                  enh;
  logic signed [2*W-1:0] data_i;
  logic signed [W-1:0]   b_i;
  logic signed [2*W-1:0] quot_o;
  logic signed [W-1:0]   rem_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  div_zero_o;

  int total = 0;
  int bad   = 0;

  funct_generator_div #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enh        (enh),
    .data_i     (data_i),
    .b_i        (b_i),
    .quot_o     (quot_o),
    .rem_o      (rem_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .div_zero_o (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint a;
    longint b;
    longint q;
    longint r;
    bit     dz;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Signed division truncating toward zero; quotient wraps to 2W bits.
  task automatic ref_div(input longint a, input longint b,
                         output longint q, output longint r, output bit dz);
    if (b == 0) begin
      q = 0; r = 0; dz = 1'b1;
    end else begin
      q  = longint'(int'(a / b));
      r  = a % b;
      dz = 1'b0;
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge that raises done_o.
  task automatic run_op(input longint a, input longint b, input int exp_lat, input string tag);
    int lat;
    int busy_cnt;
    bit seen;
    data_i = 32'(a);
    b_i    = 16'(b);
    enh    = 1'b1;
    @(posedge clk); #1;
    enh      = 1'b0;
    busy_cnt = int'(busy_o);
    lat      = 0;
    seen     = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(posedge clk); #1;
      lat++;
      if (done_o) seen = 1'b1;
      else if (busy_o) busy_cnt++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s.timeout got=no_done exp=done", tag);
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".busy_cycles"}, busy_cnt, exp_lat);
    check({tag, ".busy_at_done"}, longint'(busy_o), 0);
  endtask

  task automatic check_result(input string tag, input longint q, input longint r, input bit dz);
    check({tag, ".quot"}, longint'(quot_o), q);
    check({tag, ".rem"}, longint'(rem_o), r);
    check({tag, ".dz"}, longint'(div_zero_o), longint'(dz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint q;
    longint r;
    bit     dz;
    int     dcnt;
    int     last;
    int     pulses;

    tbl[0] = '{a: 100,           b: 7,      q: 14,          r: 2,  dz: 1'b0};
    tbl[1] = '{a: 100,           b: -7,     q: -14,         r: 2,  dz: 1'b0};
    tbl[2] = '{a: -100,          b: 7,      q: -14,         r: -2, dz: 1'b0};
    tbl[3] = '{a: -100,          b: -7,     q: 14,          r: -2, dz: 1'b0};
    tbl[4] = '{a: 0,             b: 5,      q: 0,           r: 0,  dz: 1'b0};
    tbl[5] = '{a: 1234,          b: 0,      q: 0,           r: 0,  dz: 1'b1};
    tbl[6] = '{a: 50,            b: 5,      q: 10,          r: 0,  dz: 1'b0};
    tbl[7] = '{a: 64'sd1 << 30,  b: -32768, q: -32768,      r: 0,  dz: 1'b0};
    tbl[8] = '{a: -(64'sd1 << 31), b: -1,   q: -(64'sd1 << 31), r: 0, dz: 1'b0};

    rst    = 1'b1;
    enh    = 1'b0;
    data_i = '0;
    b_i    = '0;
    #12;
    check_result("reset", 0, 0, 1'b0);
    check("reset.busy", longint'(busy_o), 0);
    check("reset.done", longint'(done_o), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_op(tbl[i].a, tbl[i].b, tbl[i].dz ? 1 : 33, tag);
      check_result(tag, tbl[i].q, tbl[i].r, tbl[i].dz);
    end

    for (int i = 0; i < 30; i++) begin
      longint a;
      longint b;
      string  tag;
      a = longint'(int'($urandom()));
      b = longint'(shortint'($urandom_range(0, 65535)));
      if (i % 4 == 0) b = longint'($urandom_range(0, 6)) - 3;
      if (i % 10 == 3) a = -(64'sd1 << 31);
      ref_div(a, b, q, r, dz);
      tag = $sformatf("rnd%0d", i);
      run_op(a, b, dz ? 1 : 33, tag);
      check_result(tag, q, r, dz);
    end

    // Inputs and enh churn while busy must not disturb 1000/3.
    data_i = 32'sd1000;
    b_i    = 16'sd3;
    enh    = 1'b1;
    @(posedge clk); #1;
    enh  = 1'b0;
    dcnt = 0;
    for (int c = 1; c <= 50; c++) begin
      if (c >= 5 && c <= 20) begin
        enh    = 1'($urandom_range(0, 1));
        data_i = 32'($urandom());
        b_i    = 16'($urandom());
      end else begin
        enh = 1'b0;
      end
      @(posedge clk); #1;
      if (done_o) dcnt++;
    end
    check("busy_enh.done_count", dcnt, 1);
    check_result("busy_enh", 333, 1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      data_i = 32'($urandom());
      b_i    = 16'($urandom());
      @(posedge clk); #1;
      check_result("hold", 333, 1, 1'b0);
      check("hold.done", longint'(done_o), 0);
      check("hold.busy", longint'(busy_o), 0);
    end

    // Asynchronous reset mid-operation.
    data_i = 32'sd500;
    b_i    = 16'sd7;
    enh    = 1'b1;
    @(posedge clk); #1;
    enh = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_result("mid_rst", 0, 0, 1'b0);
    check("mid_rst.busy", longint'(busy_o), 0);
    check("mid_rst.done", longint'(done_o), 0);
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
    @(posedge clk); #1;
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_o || busy_o) dcnt++;
    end
    check("post_rst.activity", dcnt, 0);
    run_op(77, -8, 33, "post_rst");
    check_result("post_rst", -9, 5, 1'b0);

    // enh held high: one op per 34 cycles.
    data_i = 32'sd9;
    b_i    = 16'sd2;
    enh    = 1'b1;
    last   = -1;
    pulses = 0;
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk); #1;
      if (done_o) begin
        if (pulses > 0) check("cont.interval", c - last, 34);
        check_result("cont", 4, 1, 1'b0);
        last = c;
        pulses++;
      end
    end
    enh = 1'b0;
    check("cont.pulses", pulses, 3);
    repeat (40) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/funct_generator_div.md
Name: funct_generator_div

Overview:
Sequential signed divider, the inverse of funct_generator_multi. It takes a 2*DATA_WIDTH product-width dividend and a DATA_WIDTH divisor and recovers the quotient and remainder.
- Radix-2 restoring division on magnitudes, one quotient bit per clock, sign correction in a final cycle.
- Sits on the consumer side of the generator/FIFO path, so multiplier outputs can be divided back to their operands.

Parameters:
DATA_WIDTH, `DATA_WIDTH (gen_fifo_defines_pkg), operand width W; dividend and quotient are 2W.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
enh  input  1  start request; sampled only in IDLE
data_i  input  2W signed  dividend
b_i  input  W signed  divisor
quot_o  output  2W signed  quotient, truncated toward zero
rem_o  output  W signed  remainder, sign follows dividend
busy_o  output  1  high while an operation is in progress
done_o  output  1  one-cycle pulse when quot_o/rem_o are updated
div_zero_o  output  1  set with done_o when divisor was 0; held until next done_o

Behaviour:
- Reset (async, any time including mid-operation):
  - State returns to IDLE.
  - quot_o, rem_o, busy_o, done_o, div_zero_o all go to 0.
  - Iteration counter and working registers are cleared; the in-flight operation is discarded.
- States: IDLE, CALC, FIX.
- IDLE:
  - Accept edge (edge 0) is any rising edge with enh=1.
  - At edge 0: latch |data_i| (2W-bit unsigned, so -2^(2W-1) is representable), |b_i|, both sign bits, and a divisor-zero flag. Clear the partial remainder and set counter=2W.
  - Go to CALC, or straight to FIX if b_i==0.
  - enh=0: stay in IDLE; all outputs hold their values (quot_o, rem_o, div_zero_o stable).
- CALC, one iteration per edge, edges 1..2W:
  - Shift the partial remainder (W+1 bits) left and bring in the next dividend MSB.
  - If partial remainder >= |divisor|: subtract and shift in quotient bit 1; else shift in 0.
  - Decrement counter; go to FIX when it reaches 0.
- FIX, edge 2W+1:
  - quot_o = quotient magnitude, negated if sign(data_i) != sign(b_i).
  - rem_o = remainder magnitude, negated if data_i was negative.
  - done_o=1 for exactly the following cycle; div_zero_o=0; return to IDLE.
- Divide-by-zero path: accept at edge 0 -> FIX at edge 1 with quot_o=0, rem_o=0, div_zero_o=1, done_o pulse. Latency is 1 edge.
- Latency:
  - Normal: done_o and new results follow the 2W+1th edge after the accept edge.
  - busy_o is 1 from edge 0 until edge 2W+1 and falls in the same cycle done_o rises.
- enh while busy_o=1 is ignored: no queuing, no effect on the current operation.
- Back-to-back: enh=1 during the done_o cycle (state IDLE) is accepted, giving one op per 2W+2 cycles.
- Overflow: data_i=-2^(2W-1), b_i=-1 gives quot_o = -2^(2W-1) (two's-complement wrap), rem_o=0, no flag.
- Width rules:
  - |remainder| < |b_i| <= 2^(W-1), so rem_o never overflows W signed.
  - Intermediate compare/subtract is W+1 bits, unsigned.
- Inputs data_i/b_i are only sampled at the accept edge; later changes have no effect.

Test Plan:
(W=16, so latency 33 edges.)
- 100/7 and 100/-7, accept at edge 0:
  - 100/7 -> busy_o high 33 cycles; done_o after edge 33; quot_o=14, rem_o=2.
  - 100/-7 -> quot_o=-14, rem_o=2.
- -100/7 -> quot_o=-14, rem_o=-2; -100/-7 -> quot_o=14, rem_o=-2; 0/5 -> quot_o=0, rem_o=0.
- Divide by zero and round-trip with the multiplier:
  - b_i=0, data_i=1234 -> done_o after edge 1, div_zero_o=1, quot_o=0, rem_o=0.
  - The next op 50/5 -> div_zero_o=0, quot_o=10.
  - data_i=2^30 (=-32768*-32768), b_i=-32768 -> quot_o=-32768, rem_o=0.
  - data_i=-2^31, b_i=-1 -> quot_o=-2^31, rem_o=0.
- Pulse enh and toggle data_i/b_i at cycles 5..20 of an active 1000/3 op -> result still 333 rem 1, exactly one done_o. Then hold enh=0 for 10 cycles -> all outputs stable.
- Assert rst at cycle 10 of an op, asynchronously mid-cycle:
  - All outputs go 0 immediately, with no done_o.
  - After release, 77/-8 -> quot_o=-9, rem_o=5.
- enh held high continuously with 9/2 -> done_o pulses every 34 cycles with quot_o=4, rem_o=1.
